// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage. It provides word/byte RAM access with
// programmable wait states, plus range and alignment checking.
module dmem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic              ByteM,
   input  logic [ADDR_W-1:0] AddrM,
   input  logic [31:0]       WriteDataM,
   output logic [31:0]       ReadDataM,
   output logic              MemStallM,
   output logic              AddrErrM
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             req;
   logic             out_of_range;
   logic             misaligned;
   logic             addr_err;
   logic             complete;
   logic             write_en;
   logic [IDX_W-1:0] word_idx;
   logic [1:0]       lane;
   logic [31:0]      word_rd;
   logic [31:0]      mem_q [DEPTH];

   assign req          = MemReadM | MemWriteM;
   assign word_idx     = AddrM[IDX_W+1:2];
   assign lane         = AddrM[1:0];
   assign out_of_range = (AddrM >> (IDX_W + 2)) != '0;
   assign misaligned   = !ByteM && (lane != 2'b00);
   assign addr_err     = out_of_range | misaligned;

   always_comb begin
      // NOTE: defaults first so every path assigns every signal; no latches.
      state_d   = state_q;
      cnt_d     = cnt_q;
      MemStallM = 1'b0;
      if (WAIT_CYCLES != 0 && !reset) begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  MemStallM = 1'b1;
                  cnt_d     = 4'(WAIT_CYCLES - 1);
                  state_d   = (WAIT_CYCLES == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               MemStallM = 1'b1;
               cnt_d     = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A held request re-entering IDLE after DONE belongs to the next instruction.
   assign complete = !reset && req && ((WAIT_CYCLES == 0) || (state_q == DONE));
   assign write_en = complete && MemWriteM && !addr_err;
   assign AddrErrM = complete && addr_err;
   assign word_rd  = mem_q[word_idx];

   always_comb begin
      ReadDataM = '0;
      if (complete && MemReadM && !MemWriteM && !addr_err)
         ReadDataM = ByteM ? {24'h0, word_rd[{lane, 3'b000} +: 8]} : word_rd;
   end

   // NOTE: the RAM array has no reset; its contents survive reset by design.
   always_ff @(posedge clk) begin
      if (write_en) begin
         if (ByteM) mem_q[word_idx][{lane, 3'b000} +: 8] <= WriteDataM[7:0];
         else       mem_q[word_idx] <= WriteDataM;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. It runs five instances (WAIT_CYCLES 0..4)
// against a simple array model of the RAM.
module tb_dmem_responder;

   localparam int NUM   = 5;
   localparam int DEPTH = 64;

   typedef struct {
      int          k;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_in    [NUM];
   logic        wr_in    [NUM];
   logic        byte_in  [NUM];
   logic [31:0] addr_in  [NUM];
   logic [31:0] wdata_in [NUM];
   logic [31:0] rdata_out[NUM];
   logic        stall_out[NUM];
   logic        err_out  [NUM];

   exp_t        sb[$];
   logic [31:0] model[NUM][DEPTH];
   int          scnt[NUM];
   int          checks = 0;
   int          fails  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NUM; g++) begin : g_dut
      dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(g), .ADDR_W(32)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .MemReadM  (rd_in[g]),
         .MemWriteM (wr_in[g]),
         .ByteM     (byte_in[g]),
         .AddrM     (addr_in[g]),
         .WriteDataM(wdata_in[g]),
         .ReadDataM (rdata_out[g]),
         .MemStallM (stall_out[g]),
         .AddrErrM  (err_out[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a request cycle without a stall is a completion and pops the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int k = 0; k < NUM; k++) scnt[k] = 0;
         end else begin
            for (int k = 0; k < NUM; k++) begin
               if (rd_in[k] | wr_in[k]) begin
                  if (stall_out[k]) begin
                     scnt[k]++;
                     check("stall_rdata", rdata_out[k], 32'h0);
                     check("stall_err", 32'(err_out[k]), 32'h0);
                  end else begin
                     check("stall_count", 32'(scnt[k]), 32'(k));
                     scnt[k] = 0;
                     if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL sb_underflow: dut %0d completed with no expected entry", k);
                     end else begin
                        e = sb.pop_front();
                        check("sb_dut", 32'(e.k), 32'(k));
                        check("rdata", rdata_out[k], e.rdata);
                        check("err", 32'(err_out[k]), 32'(e.err));
                     end
                  end
               end else begin
                  check("idle_stall", 32'(stall_out[k]), 32'h0);
                  check("idle_rdata", rdata_out[k], 32'h0);
                  check("idle_err", 32'(err_out[k]), 32'h0);
               end
            end
         end
      end
   end

   task automatic set_in(input int k, input logic r, input logic w, input logic b,
                         input logic [31:0] a, input logic [31:0] d);
      rd_in[k]    = r;
      wr_in[k]    = w;
      byte_in[k]  = b;
      addr_in[k]  = a;
      wdata_in[k] = d;
   endtask

   // Issues one access from posedge+1 and returns at posedge+1 after its completion edge.
   task automatic access(input int k, input logic r, input logic w, input logic b,
                         input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic er;
      int   idx, ln;
      bit   done;
      er   = (a >= 32'(4 * DEPTH)) || (!b && (a % 4 != 0));
      idx  = int'(a / 4);
      ln   = int'(a % 4);
      e.k   = k;
      e.err = er;
      e.rdata = 32'h0;
      if (w) begin
         if (!er) begin
            if (b) model[k][idx][8*ln +: 8] = d[7:0];
            else   model[k][idx] = d;
         end
      end else if (!er) begin
         e.rdata = b ? ((model[k][idx] >> (8 * ln)) & 32'hFF) : model[k][idx];
      end
      sb.push_back(e);
      set_in(k, r, w, b, a, d);
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!stall_out[k]) done = 1'b1;
      end
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL timeout: dut %0d addr %h never completed", k, a);
         void'(sb.pop_back());
         set_in(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k, input int n);
      set_in(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Store that is aborted by reset in its second stall cycle; the model is untouched.
   task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] d);
      set_in(k, 1'b0, 1'b1, 1'b0, a, d);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      set_in(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("reset_stall", 32'(stall_out[k]), 32'h0);
      check("reset_err", 32'(err_out[k]), 32'h0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r, w, b;
      logic [31:0] a, d;
      int          mode;
      reset = 1'b1;
      for (int k = 0; k < NUM; k++) begin
         set_in(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         for (int i = 0; i < DEPTH; i++) model[k][i] = 32'h0;
         scnt[k] = 0;
      end
      // Outputs must stay quiet under reset even with a request applied.
      set_in(4, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      set_in(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall4", 32'(stall_out[4]), 32'h0);
      check("rst_rdata0", rdata_out[0], 32'h0);
      check("rst_err0", 32'(err_out[0]), 32'h0);
      set_in(4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_in(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < NUM; k++) begin
         // Establish the zero initial contents through the normal write path.
         for (int i = 0; i < DEPTH; i++) access(k, 1'b0, 1'b1, 1'b0, 32'(4 * i), 32'h0);
         idle(k, 2);

         access(k, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
         access(k, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
         access(k, 1'b0, 1'b1, 1'b1, 32'h12, 32'h0000005A);
         access(k, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
         access(k, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0);
         idle(k, 1);
         access(k, 1'b0, 1'b1, 1'b0, 32'h100, 32'h12345678);
         access(k, 1'b1, 1'b0, 1'b0, 32'h06, 32'h0);
         access(k, 1'b0, 1'b1, 1'b1, 32'hFC, 32'h000000A5);
         access(k, 1'b0, 1'b1, 1'b1, 32'h100, 32'h000000A5);
         access(k, 1'b1, 1'b0, 1'b0, 32'hFC, 32'h0);
         access(k, 1'b1, 1'b1, 1'b0, 32'h08, 32'hCAFEF00D);
         access(k, 1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
         access(k, 1'b1, 1'b0, 1'b1, 32'h0B, 32'h0);
         idle(k, 2);
      end

      abort_store(4, 32'h20, 32'h11223344);
      access(4, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      idle(4, 2);

      for (int k = 0; k < NUM; k++) begin
         for (int n = 0; n < 40; n++) begin
            w    = 1'($urandom_range(0, 1));
            r    = !w || ($urandom_range(0, 7) == 0);
            b    = 1'($urandom_range(0, 1));
            d    = $urandom;
            mode = $urandom_range(0, 19);
            if (mode < 14)      a = 32'($urandom_range(0, 63));
            else if (mode < 17) a = 32'($urandom_range(0, 255));
            else                a = $urandom;
            access(k, r, w, b, a, d);
            if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 2));
         end
         idle(k, 2);
      end

      repeat (3) @(posedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
